// File: rtl/bdd_pkg.sv
// rtl/bdd_pkg.sv - shared widths, node-word field offsets and FSM state enum for the BDD node walker
package bdd_pkg;

  localparam int BDD_ADDR_WIDTH  = 10;
  localparam int BDD_ACC_WIDTH   = 20;
  localparam int BDD_CLASS_WIDTH = 4;
  localparam int BDD_MAX_DEPTH   = 15;

  // Node word layout, LSB first: left | right | threshold | leaf flag
  localparam int LEFT_LSB = 0;

  function automatic int right_lsb(input int aw);
    return aw;
  endfunction

  function automatic int thr_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int leaf_bit(input int aw, input int accw);
    return 2 * aw + accw;
  endfunction

  function automatic int node_width(input int aw, input int accw);
    return leaf_bit(aw, accw) + 1;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_WAIT_ACC = 3'd3,
    ST_DECIDE   = 3'd4,
    ST_DONE     = 3'd5
  } bdd_state_e;

endpackage

// File: rtl/bdd_node_decode.sv
// rtl/bdd_node_decode.sv - combinational split of a node word into leaf flag, threshold, children and class
module bdd_node_decode
  import bdd_pkg::*;
#(
  parameter int ADDR_WIDTH  = BDD_ADDR_WIDTH,
  parameter int ACC_WIDTH   = BDD_ACC_WIDTH,
  parameter int CLASS_WIDTH = BDD_CLASS_WIDTH,
  localparam int NODE_WIDTH = node_width(ADDR_WIDTH, ACC_WIDTH)
) (
  input  logic [NODE_WIDTH-1:0]  node_data,
  output logic                   leaf,
  output logic [ACC_WIDTH-1:0]   threshold,
  output logic [ADDR_WIDTH-1:0]  right,
  output logic [ADDR_WIDTH-1:0]  left,
  output logic [CLASS_WIDTH-1:0] leaf_class
);

  localparam int RIGHT_LSB = right_lsb(ADDR_WIDTH);
  localparam int THR_LSB   = thr_lsb(ADDR_WIDTH);
  localparam int LEAF_BIT  = leaf_bit(ADDR_WIDTH, ACC_WIDTH);

  // Leaf class overlays the low bits; the other fields are meaningless for a leaf.
  always_comb begin
    leaf       = node_data[LEAF_BIT];
    threshold  = node_data[THR_LSB +: ACC_WIDTH];
    right      = node_data[RIGHT_LSB +: ADDR_WIDTH];
    left       = node_data[LEFT_LSB +: ADDR_WIDTH];
    leaf_class = node_data[CLASS_WIDTH-1:0];
  end

endmodule

// File: rtl/bdd_node_walker.sv
// rtl/bdd_node_walker.sv - walks a threshold tree using MAC results until a leaf class is found
// Optional depth-limit abort is enabled by defining BDD_DEPTH_GUARD_EN.
module bdd_node_walker
  import bdd_pkg::*;
#(
  parameter int ADDR_WIDTH  = BDD_ADDR_WIDTH,
  parameter int ACC_WIDTH   = BDD_ACC_WIDTH,
  parameter int CLASS_WIDTH = BDD_CLASS_WIDTH,
  parameter int MAX_DEPTH   = BDD_MAX_DEPTH,
  localparam int NODE_WIDTH = node_width(ADDR_WIDTH, ACC_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  root_addr,
  output logic                   busy,
  output logic                   done,
  output logic [CLASS_WIDTH-1:0] class_out,
  output logic                   err,
  output logic                   node_rd_en,
  output logic [ADDR_WIDTH-1:0]  node_addr,
  input  logic [NODE_WIDTH-1:0]  node_data,
  output logic                   mac_start,
  output logic [ADDR_WIDTH-1:0]  mac_node,
  input  logic                   acc_valid,
  input  logic [ACC_WIDTH-1:0]   acc
);

  bdd_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]  cur_q, cur_d;
  logic [ADDR_WIDTH-1:0]  left_q, left_d;
  logic [ADDR_WIDTH-1:0]  right_q, right_d;
  logic [ADDR_WIDTH-1:0]  mac_node_q, mac_node_d;
  logic [ACC_WIDTH-1:0]   thr_q, thr_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CLASS_WIDTH-1:0] class_q, class_d;

  logic                   dec_leaf;
  logic [ACC_WIDTH-1:0]   dec_thr;
  logic [ADDR_WIDTH-1:0]  dec_right;
  logic [ADDR_WIDTH-1:0]  dec_left;
  logic [CLASS_WIDTH-1:0] dec_class;

`ifdef BDD_DEPTH_GUARD_EN
  localparam int DEPTH_W = ($clog2(MAX_DEPTH + 1) < 4) ? 4 : $clog2(MAX_DEPTH + 1);
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic               depth_hit;
  assign depth_hit = (depth_q == DEPTH_W'(MAX_DEPTH));
`else
  logic unused_max_depth;
  assign unused_max_depth = (MAX_DEPTH != 0);
`endif

  bdd_node_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH),
    .CLASS_WIDTH (CLASS_WIDTH)
  ) u_decode (
    .node_data  (node_data),
    .leaf       (dec_leaf),
    .threshold  (dec_thr),
    .right      (dec_right),
    .left       (dec_left),
    .leaf_class (dec_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= '0;
      left_q     <= '0;
      right_q    <= '0;
      mac_node_q <= '0;
      thr_q      <= '0;
      acc_q      <= '0;
      class_q    <= '0;
`ifdef BDD_DEPTH_GUARD_EN
      depth_q    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      cur_q      <= cur_d;
      left_q     <= left_d;
      right_q    <= right_d;
      mac_node_q <= mac_node_d;
      thr_q      <= thr_d;
      acc_q      <= acc_d;
      class_q    <= class_d;
`ifdef BDD_DEPTH_GUARD_EN
      depth_q    <= depth_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_FETCH;
      ST_FETCH:    state_d = ST_LOAD;
      ST_LOAD:     state_d = dec_leaf ? ST_DONE : ST_WAIT_ACC;
      ST_WAIT_ACC: if (acc_valid) state_d = ST_DECIDE;
`ifdef BDD_DEPTH_GUARD_EN
      ST_DECIDE:   state_d = depth_hit ? ST_DONE : ST_FETCH;
`else
      ST_DECIDE:   state_d = ST_FETCH;
`endif
      ST_DONE:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Result registers are loaded on entry to DONE so they are valid alongside done.
  always_comb begin
    cur_d      = cur_q;
    left_d     = left_q;
    right_d    = right_q;
    mac_node_d = mac_node_q;
    thr_d      = thr_q;
    acc_d      = acc_q;
    class_d    = class_q;
`ifdef BDD_DEPTH_GUARD_EN
    depth_d    = depth_q;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_d = root_addr;
`ifdef BDD_DEPTH_GUARD_EN
          depth_d = '0;
`endif
        end
      end
      ST_LOAD: begin
        thr_d   = dec_thr;
        left_d  = dec_left;
        right_d = dec_right;
        if (dec_leaf) begin
          class_d = dec_class;
`ifdef BDD_DEPTH_GUARD_EN
          err_d   = 1'b0;
`endif
        end else begin
          mac_node_d = cur_q;
        end
      end
      ST_WAIT_ACC: begin
        if (acc_valid) acc_d = acc;
      end
      ST_DECIDE: begin
`ifdef BDD_DEPTH_GUARD_EN
        if (depth_hit) begin
          class_d = '0;
          err_d   = 1'b1;
        end else begin
          cur_d   = (acc_q >= thr_q) ? right_q : left_q;
          depth_d = depth_q + DEPTH_W'(1);
        end
`else
        cur_d = (acc_q >= thr_q) ? right_q : left_q;
`endif
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    node_rd_en = (state_q == ST_FETCH);
    mac_start  = (state_q == ST_LOAD) && !dec_leaf;
    node_addr  = cur_q;
    mac_node   = mac_node_q;
    class_out  = class_q;
`ifdef BDD_DEPTH_GUARD_EN
    err        = err_q;
`else
    err        = 1'b0;
`endif
  end

endmodule
